// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - instruction fetch unit feeding a circular instruction queue
// Issues aligned icache reads, enqueues one-cycle-late responses and presents the queue head to decode.
module if_fetch_queue #(
  parameter int          FETCH_WIDTH = 2,
  parameter int          IMEM_AW     = 8,
  parameter int          QDEPTH      = 4,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic                     in_clk,
  input  logic                     in_rst,
  input  logic                     in_redirect,
  input  logic [31:0]              in_redirect_pc,
  output logic                     out_imem_en,
  output logic [IMEM_AW-1:0]       out_imem_addr,
  input  logic [32*FETCH_WIDTH-1:0] in_imem_rdata,
  output logic [FETCH_WIDTH-1:0]   out_valid,
  output logic [32*FETCH_WIDTH-1:0] out_instr,
  output logic [32*FETCH_WIDTH-1:0] out_pc_plus4,
  input  logic [1:0]               in_take
);

  localparam int          PW          = $clog2(QDEPTH);
  localparam int          CW          = PW + 1;
  localparam logic [31:0] GROUP_BYTES = 32'(4 * FETCH_WIDTH);

  logic [31:0]   r_fpc;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic          r_inflight;
  logic          r_infl_skip;
  logic [31:0]   r_infl_pc;
  logic [31:0]   r_q_instr [QDEPTH];
  logic [31:0]   r_q_pcp4  [QDEPTH];

  logic [CW-1:0] w_infl_words;
  logic [CW-1:0] w_deq;
  logic          w_room;
  logic          w_issue;
  logic          w_skip;
  logic [31:0]   w_group;
  logic [31:0]   w_src [FETCH_WIDTH];

  assign w_infl_words = r_inflight ? (r_infl_skip ? CW'(1) : CW'(FETCH_WIDTH)) : '0;

  always_comb begin
    w_deq = CW'(in_take);
    if (w_deq > r_count) w_deq = r_count;
    if (w_deq > CW'(FETCH_WIDTH)) w_deq = CW'(FETCH_WIDTH);
  end

  // Space check credits this cycle's dequeue so a full-rate consumer never stalls fetch.
  assign w_room  = (int'(r_count) - int'(w_deq) + int'(w_infl_words) + FETCH_WIDTH) <= QDEPTH;
  assign w_issue = !in_rst && !in_redirect && w_room;
  assign w_skip  = (FETCH_WIDTH == 2) && r_fpc[2];
  assign w_group = r_fpc & ~(GROUP_BYTES - 32'd1);

  assign out_imem_en   = w_issue;
  assign out_imem_addr = w_group[IMEM_AW+1:2];

  for (genvar k = 0; k < FETCH_WIDTH; k++) begin : g_slot
    logic [PW-1:0] w_idx;
    assign w_idx    = r_rd_ptr + PW'(k);
    // An odd-word group delivers only the upper word, which lands in the first free entry.
    assign w_src[k] = (r_infl_skip && k == 0) ? in_imem_rdata[32*(FETCH_WIDTH-1) +: 32]
                                              : in_imem_rdata[32*k +: 32];
    assign out_valid[k]             = r_count > CW'(k);
    assign out_instr[32*k +: 32]    = out_valid[k] ? r_q_instr[w_idx] : 32'h0;
    assign out_pc_plus4[32*k +: 32] = out_valid[k] ? r_q_pcp4[w_idx]  : 32'h0;
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_fpc      <= RESET_PC;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_inflight <= 1'b0;
    end else if (in_redirect) begin
      r_fpc      <= {in_redirect_pc[31:2], 2'b00};
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_inflight <= 1'b0;
    end else begin
      for (int k = 0; k < FETCH_WIDTH; k++) begin
        if (CW'(k) < w_infl_words) begin
          r_q_instr[r_wr_ptr + PW'(k)] <= w_src[k];
          r_q_pcp4[r_wr_ptr + PW'(k)]  <= r_infl_pc + 32'(4 * k + 4);
        end
      end
      r_wr_ptr    <= r_wr_ptr + PW'(w_infl_words);
      r_rd_ptr    <= r_rd_ptr + PW'(w_deq);
      r_count     <= r_count + w_infl_words - w_deq;
      r_inflight  <= w_issue;
      r_infl_skip <= w_skip;
      r_infl_pc   <= r_fpc;
      if (w_issue) r_fpc <= w_group + GROUP_BYTES;
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb/tb_if_fetch_queue.sv - directed vector bench for if_fetch_queue
// Icache model returns word i = 32'h1000_0000 + i; expectations are hand-computed per cycle.
module tb_if_fetch_queue;

  logic        in_clk = 1'b0;
  logic        in_rst = 1'b1;
  logic        in_redirect = 1'b0;
  logic [31:0] in_redirect_pc = 32'h0;
  logic        out_imem_en;
  logic [7:0]  out_imem_addr;
  logic [63:0] in_imem_rdata;
  logic [1:0]  out_valid;
  logic [63:0] out_instr;
  logic [63:0] out_pc_plus4;
  logic [1:0]  in_take = 2'd0;

  int checks = 0;
  int failures = 0;

  if_fetch_queue dut (
    .in_clk        (in_clk),
    .in_rst        (in_rst),
    .in_redirect   (in_redirect),
    .in_redirect_pc(in_redirect_pc),
    .out_imem_en   (out_imem_en),
    .out_imem_addr (out_imem_addr),
    .in_imem_rdata (in_imem_rdata),
    .out_valid     (out_valid),
    .out_instr     (out_instr),
    .out_pc_plus4  (out_pc_plus4),
    .in_take       (in_take)
  );

  always #5 in_clk = ~in_clk;

  function automatic logic [31:0] w(input int i);
    return 32'h1000_0000 + 32'(i);
  endfunction

  always @(posedge in_clk) begin
    if (out_imem_en)
      in_imem_rdata <= {w(int'(out_imem_addr | 8'd1)), w(int'(out_imem_addr))};
  end

  typedef struct {
    logic        rst;
    logic        redir;
    logic [31:0] rpc;
    logic [1:0]  take;
    logic        en;
    logic [7:0]  addr;
    logic        chk;
    logic [1:0]  valid;
    logic [31:0] i0, i1, p0, p1;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic redir, input logic [31:0] rpc, input logic [1:0] take,
                     input logic en, input logic [7:0] addr, input logic chk, input logic [1:0] valid,
                     input logic [31:0] i0, input logic [31:0] i1, input logic [31:0] p0, input logic [31:0] p1);
    vec_t v;
    v.rst = rst; v.redir = redir; v.rpc = rpc; v.take = take; v.en = en; v.addr = addr;
    v.chk = chk; v.valid = valid; v.i0 = i0; v.i1 = i1; v.p0 = p0; v.p1 = p1;
    vecs.push_back(v);
  endtask

  task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  initial begin
    logic [31:0] p;

    // reset, fill with in_take=0
    add(1,0,0,0, 0,8'd0,  0,2'd0, 0,0,0,0);
    add(0,0,0,0, 1,8'd0,  1,2'd0, 0,0,0,0);
    add(0,0,0,0, 1,8'd2,  1,2'd0, 0,0,0,0);
    add(0,0,0,0, 0,8'd0,  1,2'd3, w(0),w(1),32'h4,32'h8);
    add(0,0,0,0, 0,8'd0,  1,2'd3, w(0),w(1),32'h4,32'h8);
    add(0,0,0,0, 0,8'd0,  1,2'd3, w(0),w(1),32'h4,32'h8);
    // redirect to odd word while full; take ignored
    add(0,1,32'h14,2, 0,8'd0, 1,2'd3, w(0),w(1),32'h4,32'h8);
    add(0,0,0,0, 1,8'd4,  1,2'd0, 0,0,0,0);
    add(0,0,0,0, 1,8'd6,  1,2'd0, 0,0,0,0);
    add(0,0,0,0, 0,8'd0,  1,2'd1, w(5),0,32'h18,0);
    add(0,0,0,1, 1,8'd8,  1,2'd3, w(5),w(6),32'h18,32'h1c);
    add(0,0,0,1, 0,8'd0,  1,2'd3, w(6),w(7),32'h1c,32'h20);
    add(0,0,0,2, 1,8'd10, 1,2'd3, w(7),w(8),32'h20,32'h24);
    // over-take with count=1 plus simultaneous enqueue of 2
    add(0,0,0,2, 1,8'd12, 1,2'd1, w(9),0,32'h28,0);
    add(0,0,0,0, 0,8'd0,  1,2'd3, w(10),w(11),32'h2c,32'h30);
    add(0,0,0,2, 1,8'd14, 1,2'd3, w(10),w(11),32'h2c,32'h30);
    // reset with entries queued and a request in flight
    add(1,0,0,0, 0,8'd0,  1,2'd3, w(12),w(13),32'h34,32'h38);
    add(0,0,0,0, 1,8'd0,  1,2'd0, 0,0,0,0);
    add(0,0,0,0, 1,8'd2,  1,2'd0, 0,0,0,0);
    // redirect the cycle after an issue: words 2,3 must never appear
    add(0,1,32'h40,0, 0,8'd0, 1,2'd3, w(0),w(1),32'h4,32'h8);
    add(0,0,0,0, 1,8'd16, 1,2'd0, 0,0,0,0);
    add(0,0,0,0, 1,8'd18, 1,2'd0, 0,0,0,0);
    add(0,0,0,0, 0,8'd0,  1,2'd3, w(16),w(17),32'h44,32'h48);
    // back-to-back redirects, last wins
    add(0,1,32'h80,0, 0,8'd0, 1,2'd3, w(16),w(17),32'h44,32'h48);
    add(0,1,32'h0f,0, 0,8'd0, 1,2'd0, 0,0,0,0);
    add(0,0,0,0, 1,8'd2,  1,2'd0, 0,0,0,0);
    add(0,0,0,0, 1,8'd4,  1,2'd0, 0,0,0,0);
    add(0,0,0,0, 0,8'd0,  1,2'd1, w(3),0,32'h10,0);
    add(0,0,0,0, 0,8'd0,  1,2'd3, w(3),w(4),32'h10,32'h14);
    // PC wraps through 2^32
    add(0,1,32'hffff_fff8,0, 0,8'd0, 1,2'd3, w(3),w(4),32'h10,32'h14);
    add(0,0,0,0, 1,8'hfe, 1,2'd0, 0,0,0,0);
    add(0,0,0,0, 1,8'd0,  1,2'd0, 0,0,0,0);
    add(0,0,0,0, 0,8'd0,  1,2'd3, w(254),w(255),32'hffff_fffc,32'h0);
    add(0,0,0,2, 1,8'd2,  1,2'd3, w(254),w(255),32'hffff_fffc,32'h0);
    add(0,0,0,0, 0,8'd0,  1,2'd3, w(0),w(1),32'h4,32'h8);

    foreach (vecs[i]) begin
      @(negedge in_clk);
      in_rst = vecs[i].rst; in_redirect = vecs[i].redir;
      in_redirect_pc = vecs[i].rpc; in_take = vecs[i].take;
      #1;
      cmp($sformatf("v%0d.en", i), 64'(out_imem_en), 64'(vecs[i].en));
      if (vecs[i].en) cmp($sformatf("v%0d.addr", i), 64'(out_imem_addr), 64'(vecs[i].addr));
      if (vecs[i].chk) begin
        cmp($sformatf("v%0d.valid", i), 64'(out_valid), 64'(vecs[i].valid));
        cmp($sformatf("v%0d.instr", i), out_instr, {vecs[i].i1, vecs[i].i0});
        cmp($sformatf("v%0d.pcp4", i), out_pc_plus4, {vecs[i].p1, vecs[i].p0});
      end
    end

    // sustained full-rate consumption from reset
    @(negedge in_clk);
    in_rst = 1'b1; in_redirect = 1'b0; in_take = 2'd2;
    p = 32'h4;
    for (int c = 0; c < 20; c++) begin
      @(negedge in_clk);
      in_rst = 1'b0;
      #1;
      cmp($sformatf("s%0d.en", c), 64'(out_imem_en), 64'(1));
      if (c < 2) begin
        cmp($sformatf("s%0d.valid", c), 64'(out_valid), 64'(0));
      end else begin
        cmp($sformatf("s%0d.valid", c), 64'(out_valid), 64'(3));
        cmp($sformatf("s%0d.pcp4", c), out_pc_plus4, {p + 32'h4, p});
        cmp($sformatf("s%0d.instr", c), out_instr, {w(int'(p >> 2)), w(int'(p >> 2) - 1)});
        p = p + 32'h8;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
